// File: rtl/dram_cmd_responder.sv
// DRAM-side responder for the controller command handshake: tracks open rows per bank,
// enforces ACTIVATE/READ/WRITE/REFRESH latencies, flags illegal commands, and requests periodic refresh.
module dram_cmd_responder #(
  parameter int unsigned NUM_OF_BANKS = 8,
  parameter int unsigned NUM_OF_ROWS  = 128,
  parameter int unsigned NUM_OF_COLS  = 8,
  parameter int unsigned T_RCD        = 3,
  parameter int unsigned T_CL         = 3,
  parameter int unsigned T_WR         = 4,
  parameter int unsigned T_RP         = 3,
  parameter int unsigned T_RFC        = 10,
  parameter int unsigned T_REFI       = 780
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    cmd_req,
  input  logic [1:0]              cmd,
  input  logic [NUM_OF_BANKS-1:0] bank_sel,
  input  logic [NUM_OF_ROWS-1:0]  row_sel,
  input  logic [NUM_OF_COLS-1:0]  col_sel,
  output logic                    cmd_ack,
  output logic                    cmd_err,
  output logic [NUM_OF_BANKS-1:0] bank_open,
  output logic                    busy,
  output logic                    refresh_due
);

  localparam int unsigned BANK_W = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
  localparam int unsigned ROW_W  = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
  localparam int unsigned REFI_W = $clog2(T_REFI + 1);
  localparam int unsigned LAT_W  = 8;

  localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_RCD    = LAT_W'(T_RCD);
  localparam logic [LAT_W-1:0] LAT_RP_RCD = LAT_W'(T_RP + T_RCD);
  localparam logic [LAT_W-1:0] LAT_CL     = LAT_W'(T_CL);
  localparam logic [LAT_W-1:0] LAT_WR     = LAT_W'(T_WR);
  localparam logic [LAT_W-1:0] LAT_RFC    = LAT_W'(T_RFC);
  localparam logic [LAT_W-1:0] LAT_RP_RFC = LAT_W'(T_RP + T_RFC);
  localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(T_REFI - 1);

  localparam logic [1:0] CMD_REFRESH  = 2'b00;
  localparam logic [1:0] CMD_ACTIVATE = 2'b01;
  localparam logic [1:0] CMD_READ     = 2'b10;

  // Latencies must fit the 8-bit down-counter and be non-zero.
  if (T_RCD < 1 || T_CL < 1 || T_WR < 1 || T_RFC < 1 || T_REFI < 1 ||
      T_RP + T_RCD > 255 || T_RP + T_RFC > 255 || T_CL > 255 || T_WR > 255) begin : g_param_err
    $error("dram_cmd_responder: illegal timing parameters");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t                               state;
  logic [LAT_W-1:0]                     lat_cnt;
  logic [1:0]                           cap_cmd;
  logic [BANK_W-1:0]                    cap_bank;
  logic [ROW_W-1:0]                     cap_row;
  logic                                 cap_err;
  logic [NUM_OF_BANKS-1:0][ROW_W-1:0]   open_row;
  logic [REFI_W-1:0]                    refi_cnt;

  logic [BANK_W-1:0] bank_idx_c;
  logic [ROW_W-1:0]  row_idx_c;
  logic              sel_open_c;
  logic              err_c;
  logic [LAT_W-1:0]  lat_c;
  logic              refresh_done_c;

  // Decode the live selects and work out legality/latency for a capture this cycle.
  always_comb begin
    bank_idx_c = '0;
    row_idx_c  = '0;
    err_c      = 1'b0;
    lat_c      = LAT_ONE;
    for (int i = 0; i < NUM_OF_BANKS; i++) begin
      if (bank_sel[i]) bank_idx_c = BANK_W'(i);
    end
    for (int i = 0; i < NUM_OF_ROWS; i++) begin
      if (row_sel[i]) row_idx_c = ROW_W'(i);
    end
    sel_open_c = |(bank_open & bank_sel);
    case (cmd)
      CMD_REFRESH: lat_c = (|bank_open) ? LAT_RP_RFC : LAT_RFC;
      CMD_ACTIVATE: begin
        if (!$onehot(bank_sel) || !$onehot(row_sel)) err_c = 1'b1;
        else if (!sel_open_c)                         lat_c = LAT_RCD;
        else if (open_row[bank_idx_c] == row_idx_c)   lat_c = LAT_ONE;
        else                                          lat_c = LAT_RP_RCD;
      end
      default: begin
        if (!$onehot(bank_sel) || !$onehot(col_sel) || !sel_open_c) err_c = 1'b1;
        else lat_c = (cmd == CMD_READ) ? LAT_CL : LAT_WR;
      end
    endcase
  end

  assign refresh_done_c = (state == ST_WAIT) && (lat_cnt == LAT_ONE) &&
                          (cap_cmd == CMD_REFRESH) && !cap_err;

  // Command FSM; bank state only changes on the edge the ack rises.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      cap_cmd   <= '0;
      cap_bank  <= '0;
      cap_row   <= '0;
      cap_err   <= 1'b0;
      open_row  <= '0;
      bank_open <= '0;
      cmd_ack   <= 1'b0;
      cmd_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_req && !cmd_ack) begin
            cap_cmd  <= cmd;
            cap_bank <= bank_idx_c;
            cap_row  <= row_idx_c;
            cap_err  <= err_c;
            lat_cnt  <= lat_c;
            busy     <= 1'b1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_ONE) begin
            cmd_ack <= 1'b1;
            cmd_err <= cap_err;
            state   <= ST_ACK;
            if (!cap_err) begin
              if (cap_cmd == CMD_REFRESH) begin
                bank_open <= '0;
              end else if (cap_cmd == CMD_ACTIVATE) begin
                bank_open[cap_bank] <= 1'b1;
                open_row[cap_bank]  <= cap_row;
              end
            end
          end else begin
            lat_cnt <= lat_cnt - LAT_ONE;
          end
        end
        ST_ACK: begin
          if (!cmd_req) begin
            cmd_ack <= 1'b0;
            cmd_err <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Refresh interval timer; a completing REFRESH wins over an expiring interval.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      refi_cnt    <= '0;
      refresh_due <= 1'b0;
    end else if (refresh_done_c) begin
      refi_cnt    <= '0;
      refresh_due <= 1'b0;
    end else if (!refresh_due) begin
      if (refi_cnt == REFI_LAST) refresh_due <= 1'b1;
      else                       refi_cnt    <= refi_cnt + REFI_W'(1);
    end
  end

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Directed bench for dram_cmd_responder: latency, legality, bank state, refresh timer, reset abort.
module tb_dram_cmd_responder;

  localparam logic [1:0] C_REF = 2'b00;
  localparam logic [1:0] C_ACT = 2'b01;
  localparam logic [1:0] C_RD  = 2'b10;
  localparam logic [1:0] C_WR  = 2'b11;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         cmd_req = 1'b0;
  logic [1:0]   cmd = 2'b00;
  logic [7:0]   bank_sel = '0;
  logic [127:0] row_sel = '0;
  logic [7:0]   col_sel = '0;
  logic         cmd_ack, cmd_err, busy, refresh_due;
  logic [7:0]   bank_open;

  int n_chk  = 0;
  int n_pass = 0;

  dram_cmd_responder dut (
    .clk(clk), .rst_b(rst_b), .cmd_req(cmd_req), .cmd(cmd),
    .bank_sel(bank_sel), .row_sel(row_sel), .col_sel(col_sel),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err), .bank_open(bank_open),
    .busy(busy), .refresh_due(refresh_due)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] row_oh(input int i);
    logic [127:0] one;
    one = 128'd1;
    return one << i;
  endfunction

  // Issue one command, measure edges from capture to ack, then complete the handshake.
  task automatic issue(input string tag, input logic [1:0] c, input logic [7:0] b,
                       input logic [127:0] r, input logic [7:0] col, input int exp_lat,
                       input logic exp_err, input logic [7:0] exp_open);
    int n;
    n = 0;
    @(negedge clk);
    cmd = c; bank_sel = b; row_sel = r; col_sel = col; cmd_req = 1'b1;
    @(posedge clk); #1;
    chk({tag, " busy@capture"}, 32'(busy), 32'd1);
    while (!cmd_ack && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " err"}, 32'(cmd_err), 32'(exp_err));
    chk({tag, " bank_open"}, 32'(bank_open), 32'(exp_open));
    @(negedge clk);
    cmd_req = 1'b0;
    @(posedge clk); #1;
    chk({tag, " ack fall"}, 32'({cmd_ack, cmd_err, busy}), 32'd0);
  endtask

  initial begin
    int n;
    // Reset values
    @(negedge clk); @(negedge clk);
    chk("reset outputs", 32'({cmd_ack, cmd_err, busy, refresh_due}), 32'd0);
    chk("reset bank_open", 32'(bank_open), 32'd0);
    rst_b = 1'b1;

    // Refresh interval from reset
    repeat (779) @(posedge clk);
    #1 chk("refresh_due @779", 32'(refresh_due), 32'd0);
    @(posedge clk); #1 chk("refresh_due @780", 32'(refresh_due), 32'd1);
    repeat (5) @(posedge clk);
    #1 chk("refresh_due held", 32'(refresh_due), 32'd1);

    issue("act b2 r37",   C_ACT, 8'h04, row_oh(37), 8'h00, 3, 1'b0, 8'h04);
    issue("read b2",      C_RD,  8'h04, '0,         8'h10, 3, 1'b0, 8'h04);
    issue("write b5 cls", C_WR,  8'h20, '0,         8'h01, 1, 1'b1, 8'h04);
    issue("act b2 same",  C_ACT, 8'h04, row_oh(37), 8'h00, 1, 1'b0, 8'h04);
    issue("act b2 r90",   C_ACT, 8'h04, row_oh(90), 8'h00, 6, 1'b0, 8'h04);
    issue("read b2 r90",  C_RD,  8'h04, '0,         8'h80, 3, 1'b0, 8'h04);
    issue("write b2",     C_WR,  8'h04, '0,         8'h02, 4, 1'b0, 8'h04);
    issue("act bank 06",  C_ACT, 8'h06, row_oh(1),  8'h00, 1, 1'b1, 8'h04);
    issue("act bank 00",  C_ACT, 8'h00, row_oh(1),  8'h00, 1, 1'b1, 8'h04);
    issue("act row 0",    C_ACT, 8'h01, '0,         8'h00, 1, 1'b1, 8'h04);
    issue("read col 03",  C_RD,  8'h04, '0,         8'h03, 1, 1'b1, 8'h04);
    issue("act b0 r5",    C_ACT, 8'h01, row_oh(5),  8'h00, 3, 1'b0, 8'h05);
    chk("refresh_due before REF", 32'(refresh_due), 32'd1);

    // REFRESH with banks open clears the interval; it reasserts 780 edges after the ack edge
    issue("ref open",     C_REF, 8'hFF, '0,         8'h00, 13, 1'b0, 8'h00);
    chk("refresh_due cleared", 32'(refresh_due), 32'd0);
    repeat (778) @(posedge clk);
    #1 chk("refresh_due ack+779", 32'(refresh_due), 32'd0);
    @(posedge clk); #1 chk("refresh_due ack+780", 32'(refresh_due), 32'd1);

    issue("ref closed",   C_REF, 8'h00, '0,         8'h00, 10, 1'b0, 8'h00);
    chk("refresh_due after ref2", 32'(refresh_due), 32'd0);
    issue("read after ref", C_RD, 8'h04, '0,        8'h10, 1, 1'b1, 8'h00);

    // Drop req mid-WAIT and change selects after capture: one-cycle ack, bank 3 opened
    @(negedge clk);
    cmd = C_ACT; bank_sel = 8'h08; row_sel = row_oh(10); cmd_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_req = 1'b0; bank_sel = 8'h40; cmd = C_REF;
    n = 0;
    while (!cmd_ack && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pulse latency", 32'(n), 32'd3);
    chk("pulse bank_open", 32'(bank_open), 32'h08);
    @(posedge clk); #1;
    chk("pulse ack low", 32'({cmd_ack, busy}), 32'd0);

    // Async reset mid-WAIT aborts the command
    @(negedge clk);
    cmd = C_REF; bank_sel = 8'h00; cmd_req = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("busy before abort", 32'(busy), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("abort outputs", 32'({cmd_ack, cmd_err, busy, refresh_due}), 32'd0);
    chk("abort bank_open", 32'(bank_open), 32'd0);
    repeat (15) @(posedge clk);
    #1 chk("no ack in reset", 32'(cmd_ack), 32'd0);
    @(negedge clk);
    cmd_req = 1'b0; rst_b = 1'b1;
    repeat (15) @(posedge clk);
    #1 chk("no ack after abort", 32'({cmd_ack, busy}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
